sdram_port_arbiter: RTL and testbench

Round-robin arbiter that shares the single user command port of the SDRAM controller between `NumPorts` requesters (e.g. video fetch, CPU, DMA). It latches one request per arbitration, presents it downstream with a valid/ready handshake, and routes returned read data back to the originating port through an in-order tag FIFO. It sits between the client blocks and the SDRAM controller, in the `i_dram_clk` domain.

---
 rtl/sdram_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller command port between NumPorts clients.
// Read data is routed back to the issuing port through an in-order tag FIFO.
module sdram_port_arbiter #(
    parameter int unsigned NumPorts    = 4,
    parameter int unsigned AddrWidth   = 22,
    parameter int unsigned DataWidth   = 16,
    parameter int unsigned RdFifoDepth = 4
) (
    input  logic                          i_dram_clk,
    input  logic                          i_rst,
    input  logic [NumPorts-1:0]           i_req,
    input  logic [NumPorts-1:0]           i_we,
    input  logic [NumPorts*AddrWidth-1:0] i_addr,
    input  logic [NumPorts*DataWidth-1:0] i_wdata,
    output logic [NumPorts-1:0]           o_gnt,
    output logic [NumPorts-1:0]           o_rd_valid,
    output logic [DataWidth-1:0]          o_rd_data,
    output logic                          o_cmd_valid,
    output logic                          o_cmd_we,
    output logic [AddrWidth-1:0]          o_cmd_addr,
    output logic [DataWidth-1:0]          o_cmd_wdata,
    input  logic                          i_cmd_ready,
    input  logic                          i_rd_valid,
    input  logic [DataWidth-1:0]          i_rd_data,
    output logic                          o_err
);

    localparam int unsigned PortW = $clog2(NumPorts);
    localparam int unsigned PtrW  = (RdFifoDepth > 1) ? $clog2(RdFifoDepth) : 1;
    localparam int unsigned CntW  = $clog2(RdFifoDepth) + 1;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t               state;
    logic [PortW-1:0]     last;
    logic [PortW-1:0]     cmd_port;
    logic [PortW-1:0]     winner;
    logic [PortW-1:0]     cand;
    logic                 any_elig;
    logic [NumPorts-1:0]  eligible;
    logic [AddrWidth-1:0] addr_arr  [NumPorts];
    logic [DataWidth-1:0] wdata_arr [NumPorts];

    logic [PortW-1:0]     tag_mem [RdFifoDepth];
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [CntW-1:0]      count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    assign fifo_full  = (count == CntW'(RdFifoDepth));
    assign fifo_empty = (count == '0);
    assign push       = (state == ISSUE) && i_cmd_ready && !o_cmd_we;
    assign pop        = i_rd_valid && !fifo_empty;

    always_comb begin
        for (int unsigned p = 0; p < NumPorts; p++) begin
            addr_arr[p]  = i_addr[p*AddrWidth +: AddrWidth];
            wdata_arr[p] = i_wdata[p*DataWidth +: DataWidth];
        end
    end

    // Reads are held off while the tag FIFO is full; writes need no tag.
    always_comb begin
        eligible = i_req & ~(~i_we & {NumPorts{fifo_full}});
        any_elig = 1'b0;
        winner   = '0;
        cand     = '0;
        for (int unsigned i = 1; i <= NumPorts; i++) begin
            cand = PortW'((32'(last) + i) % NumPorts);
            if (!any_elig && eligible[cand]) begin
                any_elig = 1'b1;
                winner   = cand;
            end
        end
    end

    always_ff @(posedge i_dram_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            last        <= PortW'(NumPorts - 1);
            cmd_port    <= '0;
            o_gnt       <= '0;
            o_cmd_valid <= 1'b0;
            o_cmd_we    <= 1'b0;
            o_cmd_addr  <= '0;
            o_cmd_wdata <= '0;
        end else begin
            o_gnt <= '0;
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        o_cmd_we    <= i_we[winner];
                        o_cmd_addr  <= addr_arr[winner];
                        o_cmd_wdata <= wdata_arr[winner];
                        o_cmd_valid <= 1'b1;
                        o_gnt       <= NumPorts'(1) << winner;
                        cmd_port    <= winner;
                        last        <= winner;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_cmd_ready) begin
                        o_cmd_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_dram_clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= cmd_port;
        end
    end

    always_ff @(posedge i_dram_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_rd_valid <= '0;
            o_rd_data  <= '0;
            o_err      <= 1'b0;
        end else begin
            o_rd_valid <= '0;
            if (push) begin
                wr_ptr <= (wr_ptr == PtrW'(RdFifoDepth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                o_rd_valid <= NumPorts'(1) << tag_mem[rd_ptr];
                o_rd_data  <= i_rd_data;
                rd_ptr     <= (rd_ptr == PtrW'(RdFifoDepth - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (i_rd_valid && fifo_empty) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_sdram_port_arbiter;

    localparam int NP    = 4;
    localparam int AW    = 22;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic [NP-1:0] req = '0;
    logic [NP-1:0] we  = '0;
    logic [AW-1:0] a  [NP];
    logic [DW-1:0] wd [NP];
    logic [NP*AW-1:0] addr_bus;
    logic [NP*DW-1:0] wdata_bus;
    logic          cmd_ready = 1'b1;
    logic          rdv_in    = 1'b0;
    logic [DW-1:0] rdd_in    = '0;

    logic [NP-1:0] o_gnt, o_rd_valid;
    logic [DW-1:0] o_rd_data, o_cmd_wdata;
    logic [AW-1:0] o_cmd_addr;
    logic          o_cmd_valid, o_cmd_we, o_err;

    assign addr_bus  = {a[3], a[2], a[1], a[0]};
    assign wdata_bus = {wd[3], wd[2], wd[1], wd[0]};

    sdram_port_arbiter #(
        .NumPorts(NP),
        .AddrWidth(AW),
        .DataWidth(DW),
        .RdFifoDepth(DEPTH)
    ) dut (
        .i_dram_clk (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_we       (we),
        .i_addr     (addr_bus),
        .i_wdata    (wdata_bus),
        .o_gnt      (o_gnt),
        .o_rd_valid (o_rd_valid),
        .o_rd_data  (o_rd_data),
        .o_cmd_valid(o_cmd_valid),
        .o_cmd_we   (o_cmd_we),
        .o_cmd_addr (o_cmd_addr),
        .o_cmd_wdata(o_cmd_wdata),
        .i_cmd_ready(cmd_ready),
        .i_rd_valid (rdv_in),
        .i_rd_data  (rdd_in),
        .o_err      (o_err)
    );

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: a command slot, a rotating priority pointer and a queue of tags.
    bit            m_issuing;
    int            m_last, m_tag, m_w, m_p;
    bit            m_full;
    int            tagq[$];
    logic [NP-1:0] m_gnt, m_rdv;
    logic [DW-1:0] m_rdd, m_wdata;
    logic [AW-1:0] m_addr;
    logic          m_valid, m_we, m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_issuing = 1'b0;
            m_last    = NP - 1;
            m_tag     = 0;
            tagq.delete();
            m_gnt     = '0;
            m_rdv     = '0;
            m_rdd     = '0;
            m_valid   = 1'b0;
            m_we      = 1'b0;
            m_addr    = '0;
            m_wdata   = '0;
            m_err     = 1'b0;
        end else begin
            m_full = (tagq.size() == DEPTH);
            m_rdv  = '0;
            if (rdv_in) begin
                if (tagq.size() > 0) begin
                    m_rdv[tagq[0]] = 1'b1;
                    m_rdd = rdd_in;
                    void'(tagq.pop_front());
                end else begin
                    m_err = 1'b1;
                end
            end
            m_gnt = '0;
            if (!m_issuing) begin
                m_w = -1;
                for (int k = 1; k <= NP; k++) begin
                    m_p = (m_last + k) % NP;
                    if (m_w < 0 && req[m_p] && (we[m_p] || !m_full)) m_w = m_p;
                end
                if (m_w >= 0) begin
                    m_gnt[m_w] = 1'b1;
                    m_last     = m_w;
                    m_tag      = m_w;
                    m_we       = we[m_w];
                    m_addr     = a[m_w];
                    m_wdata    = wd[m_w];
                    m_valid    = 1'b1;
                    m_issuing  = 1'b1;
                end
            end else if (cmd_ready) begin
                if (!m_we) tagq.push_back(m_tag);
                m_valid   = 1'b0;
                m_issuing = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("gnt", o_gnt, m_gnt);
            chk("cmd_valid", o_cmd_valid, m_valid);
            chk("rd_valid", o_rd_valid, m_rdv);
            chk("rd_data", o_rd_data, m_rdd);
            chk("err", o_err, m_err);
            if (m_valid) begin
                chk("cmd_we", o_cmd_we, m_we);
                chk("cmd_addr", o_cmd_addr, m_addr);
                chk("cmd_wdata", o_cmd_wdata, m_wdata);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_gnt", o_gnt, 0);
        chk("rst_cmd_valid", o_cmd_valid, 0);
        chk("rst_rd_valid", o_rd_valid, 0);
        chk("rst_err", o_err, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic issue(input int p, input bit w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        int n;
        req[p] = 1'b1;
        we[p]  = w;
        a[p]   = ad;
        wd[p]  = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_gnt[p] && n < 20);
        chk($sformatf("gnt_p%0d", p), o_gnt[p], 1);
        req[p] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    int gl[$];
    int gc[$];
    int n;

    initial begin
        for (int i = 0; i < NP; i++) begin
            a[i]  = '0;
            wd[i] = '0;
        end
        #2 rst = 1'b1;
        #1 started = 1'b1;
        @(negedge clk);
        chk("init_cmd_valid", o_cmd_valid, 0);
        chk("init_addr", o_cmd_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single write from port 2
        req[2] = 1'b1; we[2] = 1'b1; a[2] = 22'h00123; wd[2] = 16'hBEEF;
        @(negedge clk);
        chk("s1_gnt", o_gnt, 4'b0100);
        chk("s1_valid", o_cmd_valid, 1);
        chk("s1_we", o_cmd_we, 1);
        chk("s1_addr", o_cmd_addr, 22'h00123);
        chk("s1_wdata", o_cmd_wdata, 16'hBEEF);
        req[2] = 1'b0;
        @(negedge clk);
        chk("s1_idle", o_cmd_valid, 0);

        // Round-robin with all ports requesting writes
        do_reset();
        req = 4'hF; we = 4'hF;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (o_gnt != 0) begin
                gl.push_back(oh_idx(o_gnt));
                gc.push_back(c);
            end
        end
        req = '0;
        chk("rr_count", gl.size(), 8);
        for (int i = 0; i < gl.size(); i++) begin
            chk($sformatf("rr_order_%0d", i), gl[i], i % 4);
            if (i > 0) chk($sformatf("rr_gap_%0d", i), gc[i] - gc[i-1], 2);
        end
        we = '0;
        @(negedge clk);

        // Read routing: port 1 then port 3
        issue(1, 1'b0, 22'h0AAAA, 16'h0);
        issue(3, 1'b0, 22'h0BBBB, 16'h0);
        @(negedge clk);
        rdv_in = 1'b1; rdd_in = 16'h1111;
        @(negedge clk);
        rdd_in = 16'h3333;
        chk("rd1_valid", o_rd_valid, 4'b0010);
        chk("rd1_data", o_rd_data, 16'h1111);
        @(negedge clk);
        rdv_in = 1'b0;
        chk("rd2_valid", o_rd_valid, 4'b1000);
        chk("rd2_data", o_rd_data, 16'h3333);

        // FIFO full: reads masked, writes pass
        for (int i = 0; i < 4; i++) issue(3, 1'b0, AW'(22'h100 + i), 16'h0);
        req[0] = 1'b1; we[0] = 1'b0; a[0] = 22'h00200;
        req[1] = 1'b1; we[1] = 1'b1; a[1] = 22'h00300; wd[1] = 16'hCAFE;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_gnt == 0 && n < 20);
        chk("full_gnt", o_gnt, 4'b0010);
        req[1] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("full_block", o_gnt, 0);
        end
        rdv_in = 1'b1; rdd_in = 16'h5555;
        @(negedge clk);
        rdv_in = 1'b0;
        chk("full_ret_valid", o_rd_valid, 4'b1000);
        chk("full_ret_data", o_rd_data, 16'h5555);
        n = 0;
        while (!o_gnt[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("full_p0_gnt", o_gnt, 4'b0001);
        req[0] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rdv_in = 1'b1; rdd_in = DW'(16'hA000 + i);
            @(negedge clk);
        end
        rdv_in = 1'b0;
        chk("drain_last_valid", o_rd_valid, 4'b0001);
        chk("drain_last_data", o_rd_data, 16'hA003);

        // Backpressure, then reset mid-ISSUE
        cmd_ready = 1'b0;
        issue(2, 1'b1, 22'h3ABCD, 16'h1234);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", o_cmd_valid, 1);
            chk("bp_addr", o_cmd_addr, 22'h3ABCD);
            chk("bp_wdata", o_cmd_wdata, 16'h1234);
        end
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_gnt", o_gnt, 0);
        chk("mid_rst_valid", o_cmd_valid, 0);
        chk("mid_rst_we", o_cmd_we, 0);
        chk("mid_rst_addr", o_cmd_addr, 0);
        chk("mid_rst_wdata", o_cmd_wdata, 0);
        chk("mid_rst_rd_valid", o_rd_valid, 0);
        chk("mid_rst_rd_data", o_rd_data, 0);
        chk("mid_rst_err", o_err, 0);
        @(negedge clk);
        rst = 1'b0;
        cmd_ready = 1'b1;
        req[0] = 1'b1; we[0] = 1'b1; a[0] = 22'h00001;
        req[2] = 1'b1; we[2] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_gnt == 0 && n < 20);
        chk("post_rst_gnt", o_gnt, 4'b0001);
        req = '0;
        @(negedge clk);

        // Underflow: read return with nothing outstanding
        rdv_in = 1'b1; rdd_in = 16'h7777;
        @(negedge clk);
        rdv_in = 1'b0;
        chk("uf_rd_valid", o_rd_valid, 0);
        chk("uf_err", o_err, 1);
        repeat (3) @(negedge clk);
        chk("uf_err_sticky", o_err, 1);
        do_reset();
        @(negedge clk);
        chk("uf_err_cleared", o_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
